// File: rtl/pc_stack_unit_pkg.sv
// Shared command encodings for the program-counter unit and its call stack.
package pc_stack_unit_pkg;

  localparam int unsigned PC_OP_WIDTH = 3;

  typedef logic [PC_OP_WIDTH-1:0] pc_op_t;

  localparam pc_op_t PC_OP_INC    = 3'd0;
  localparam pc_op_t PC_OP_LOAD   = 3'd1;
  localparam pc_op_t PC_OP_BRANCH = 3'd2;
  localparam pc_op_t PC_OP_CALL   = 3'd3;
  localparam pc_op_t PC_OP_RET    = 3'd4;
  localparam pc_op_t PC_OP_HOLD   = 3'd5;

endpackage

// File: rtl/pc_stack_unit_call_stack.sv
// Parametrised return-address LIFO; push-when-full and pop-when-empty are dropped.
module call_stack #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 8,
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1),
  localparam int unsigned IDX_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] tos,
  output logic [CNT_WIDTH-1:0]  depth,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_WIDTH-1:0]  depth_q, depth_d;
  logic [CNT_WIDTH-1:0]  rd_cnt;
  logic [IDX_WIDTH-1:0]  wr_idx, rd_idx;
  logic                  do_push, do_pop;

  assign full  = (depth_q == CNT_WIDTH'(DEPTH));
  assign empty = (depth_q == '0);

  // An accepted push takes precedence; the unit never issues both at once.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty & ~do_push;

  assign wr_idx = depth_q[IDX_WIDTH-1:0];
  assign rd_cnt = depth_q - CNT_WIDTH'(1);
  assign rd_idx = rd_cnt[IDX_WIDTH-1:0];

  always_comb begin
    depth_d = depth_q;
    if (do_push) begin
      depth_d = depth_q + CNT_WIDTH'(1);
    end else if (do_pop) begin
      depth_d = rd_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  // Entry storage carries no reset; invalid entries are masked from tos.
  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem_q[wr_idx] <= din;
    end
  end

  assign tos   = empty ? '0 : mem_q[rd_idx];
  assign depth = depth_q;

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with relative branch, hardware call/return stack and sticky stack errors.
module pc_stack_unit
  import pc_stack_unit_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH   = 16,
  parameter int unsigned             OFFSET_WIDTH = 8,
  parameter int unsigned             STACK_DEPTH  = 8,
  parameter logic [ADDR_WIDTH-1:0]   RESET_ADDR   = '0,
  localparam int unsigned            DEPTH_WIDTH  = $clog2(STACK_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pc_en,
  input  logic [PC_OP_WIDTH-1:0]  pc_op,
  input  logic [ADDR_WIDTH-1:0]   pc_in,
  input  logic [OFFSET_WIDTH-1:0] offset,
  output logic [ADDR_WIDTH-1:0]   pc_out,
  output logic [ADDR_WIDTH-1:0]   tos,
  output logic [DEPTH_WIDTH-1:0]  depth,
  output logic                    stack_full,
  output logic                    stack_empty,
  output logic                    overflow_err,
  output logic                    underflow_err,
  input  logic                    err_clr
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pc_inc, offset_ext;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  ovf_evt, unf_evt;
  logic                  push, pop;

  assign pc_inc     = pc_q + ADDR_WIDTH'(1);
  assign offset_ext = ADDR_WIDTH'($signed(offset));

  always_comb begin
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (pc_en) begin
      case (pc_op)
        PC_OP_INC:    pc_d = pc_inc;
        PC_OP_LOAD:   pc_d = pc_in;
        PC_OP_BRANCH: pc_d = pc_q + offset_ext;
        PC_OP_CALL: begin
          if (stack_full) begin
            ovf_evt = 1'b1;
          end else begin
            push = 1'b1;
            pc_d = pc_in;
          end
        end
        PC_OP_RET: begin
          if (stack_empty) begin
            unf_evt = 1'b1;
          end else begin
            pop  = 1'b1;
            pc_d = tos;
          end
        end
        // HOLD and the reserved codes leave everything untouched.
        default: pc_d = pc_q;
      endcase
    end
  end

  // A new error event beats a simultaneous clear.
  assign ovf_d = ovf_evt | (ovf_q & ~err_clr);
  assign unf_d = unf_evt | (unf_q & ~err_clr);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_ADDR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  call_stack #(
    .DATA_WIDTH (ADDR_WIDTH),
    .DEPTH      (STACK_DEPTH)
  ) u_call_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .tos   (tos),
    .depth (depth),
    .full  (stack_full),
    .empty (stack_empty)
  );

  assign pc_out        = pc_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: a reference model queues expected state per step.
module tb_pc_stack_unit;

  localparam int unsigned AW = 16;
  localparam int unsigned OW = 8;
  localparam int unsigned SD = 8;
  localparam int unsigned DW = $clog2(SD + 1);
  localparam logic [AW-1:0] RST_PC = 16'h0100;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [AW-1:0] tos;
    logic [DW-1:0] depth;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          unf;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, pc_en, err_clr;
  logic [2:0]    pc_op;
  logic [AW-1:0] pc_in;
  logic [OW-1:0] offset;
  logic [AW-1:0] pc_out, tos;
  logic [DW-1:0] depth;
  logic          stack_full, stack_empty, overflow_err, underflow_err;

  exp_t          sb_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  // Reference model state
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_stack [SD];
  int            m_depth;
  logic          m_ovf, m_unf;

  always #5 clk = ~clk;

  pc_stack_unit #(
    .ADDR_WIDTH   (AW),
    .OFFSET_WIDTH (OW),
    .STACK_DEPTH  (SD),
    .RESET_ADDR   (RST_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_en         (pc_en),
    .pc_op         (pc_op),
    .pc_in         (pc_in),
    .offset        (offset),
    .pc_out        (pc_out),
    .tos           (tos),
    .depth         (depth),
    .stack_full    (stack_full),
    .stack_empty   (stack_empty),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err),
    .err_clr       (err_clr)
  );

  task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: scoreboard empty observed %h expected entry", tag, pc_out);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, ".pc"},    pc_out,               e.pc);
    chk({tag, ".tos"},   tos,                  e.tos);
    chk({tag, ".depth"}, AW'(depth),           AW'(e.depth));
    chk({tag, ".full"},  AW'(stack_full),      AW'(e.full));
    chk({tag, ".empty"}, AW'(stack_empty),     AW'(e.empty));
    chk({tag, ".ovf"},   AW'(overflow_err),    AW'(e.ovf));
    chk({tag, ".unf"},   AW'(underflow_err),   AW'(e.unf));
  endtask

  task automatic step(input string tag, input logic rst, input logic en, input logic [2:0] op,
                      input logic [AW-1:0] din, input logic [OW-1:0] off, input logic clr);
    exp_t e;
    logic ovf_ev, unf_ev;
    reset = rst; pc_en = en; pc_op = op; pc_in = din; offset = off; err_clr = clr;
    ovf_ev = 1'b0;
    unf_ev = 1'b0;
    if (rst) begin
      m_pc = RST_PC; m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (en) begin
        case (op)
          3'd0: m_pc = m_pc + 16'd1;
          3'd1: m_pc = din;
          3'd2: m_pc = m_pc + {{(AW-OW){off[OW-1]}}, off};
          3'd3: begin
            if (m_depth == SD) ovf_ev = 1'b1;
            else begin
              m_stack[m_depth] = m_pc + 16'd1;
              m_depth++;
              m_pc = din;
            end
          end
          3'd4: begin
            if (m_depth == 0) unf_ev = 1'b1;
            else begin
              m_depth--;
              m_pc = m_stack[m_depth];
            end
          end
          default: ;
        endcase
      end
      m_ovf = ovf_ev ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_unf = unf_ev ? 1'b1 : (clr ? 1'b0 : m_unf);
    end
    e.pc    = m_pc;
    e.tos   = (m_depth > 0) ? m_stack[m_depth-1] : '0;
    e.depth = DW'(m_depth);
    e.full  = (m_depth == SD);
    e.empty = (m_depth == 0);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  initial begin
    reset = 1'b1; pc_en = 1'b0; pc_op = '0; pc_in = '0; offset = '0; err_clr = 1'b0;
    m_pc = '0; m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
    @(posedge clk);
    #1;

    // 1: reset and increments
    step("reset", 1, 0, 3'd0, 16'h0000, 8'h00, 0);
    for (int i = 0; i < 3; i++) step("inc", 0, 1, 3'd0, 16'h0000, 8'h00, 0);

    // 2: branch and wrap cases
    step("load10",   0, 1, 3'd1, 16'h0010, 8'h00, 0);
    step("br_neg",   0, 1, 3'd2, 16'h0000, 8'hFE, 0);
    step("loadffff", 0, 1, 3'd1, 16'hFFFF, 8'h00, 0);
    step("inc_wrap", 0, 1, 3'd0, 16'h0000, 8'h00, 0);
    step("loadfff0", 0, 1, 3'd1, 16'hFFF0, 8'h00, 0);
    step("br_wrap",  0, 1, 3'd2, 16'h0000, 8'h7F, 0);

    // 3: single call/return
    step("load20", 0, 1, 3'd1, 16'h0020, 8'h00, 0);
    step("call1",  0, 1, 3'd3, 16'h0400, 8'h00, 0);
    step("ret1",   0, 1, 3'd4, 16'h0000, 8'h00, 0);

    // CALL from all-ones pushes 0
    step("loadffff2", 0, 1, 3'd1, 16'hFFFF, 8'h00, 0);
    step("call_wrap", 0, 1, 3'd3, 16'h0200, 8'h00, 0);
    step("ret_wrap",  0, 1, 3'd4, 16'h0000, 8'h00, 0);

    // 4: fill, overflow, drain
    for (int i = 0; i < SD; i++) step("call_n", 0, 1, 3'd3, 16'h1000 + 16'(i * 16'h0100), 8'h00, 0);
    step("call_ovf", 0, 1, 3'd3, 16'h0777, 8'h00, 0);
    for (int i = 0; i < SD; i++) step("ret_n", 0, 1, 3'd4, 16'h0000, 8'h00, 0);

    // 5: underflow and clear priority
    step("ret_unf",     0, 1, 3'd4, 16'h0000, 8'h00, 0);
    step("clr_and_unf", 0, 1, 3'd4, 16'h0000, 8'h00, 1);
    step("clr_alone",   0, 0, 3'd4, 16'h0000, 8'h00, 1);

    // HOLD and reserved codes
    step("hold", 0, 1, 3'd5, 16'h5555, 8'h11, 0);
    step("rsv6", 0, 1, 3'd6, 16'h5555, 8'h11, 0);
    step("rsv7", 0, 1, 3'd7, 16'h5555, 8'h11, 0);

    // 6: reset mid-sequence with a coincident CALL
    step("ret_unf2", 0, 1, 3'd4, 16'h0000, 8'h00, 0);
    step("call_a",   0, 1, 3'd3, 16'h0300, 8'h00, 0);
    step("call_b",   0, 1, 3'd3, 16'h0310, 8'h00, 0);
    step("call_c",   0, 1, 3'd3, 16'h0123, 8'h00, 0);
    step("rst_call", 1, 1, 3'd3, 16'h0999, 8'h00, 0);
    step("en_low",   0, 0, 3'd3, 16'h0999, 8'h00, 0);
    step("en_low2",  0, 0, 3'd0, 16'h0999, 8'h00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
Parametrised program-counter unit and the successor to the fixed increment/load PC. It adds PC-relative branching, a hardware call/return stack of configurable depth, and sticky overflow/underflow error reporting. It sits between the FSM (which issues one PC command per enabled cycle) and the instruction-fetch address mux.

Parameters:
ADDR_WIDTH, 16, width of PC, jump target and stack entries
OFFSET_WIDTH, 8, width of signed two's-complement branch offset
STACK_DEPTH, 8, number of return-address entries (>=2)
RESET_ADDR, 0, PC value after reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
pc_en  in  1  command strobe; pc_op is ignored when low
pc_op  in  3  command code (see Behaviour)
pc_in  in  ADDR_WIDTH  absolute target for LOAD/CALL
offset  in  OFFSET_WIDTH  signed relative offset for BRANCH
pc_out  out  ADDR_WIDTH  current PC (registered)
tos  out  ADDR_WIDTH  top-of-stack return address; 0 when empty
depth  out  $clog2(STACK_DEPTH+1)  number of valid stack entries
stack_full  out  1  depth == STACK_DEPTH
stack_empty  out  1  depth == 0
overflow_err  out  1  sticky: CALL attempted while full
underflow_err  out  1  sticky: RET attempted while empty
err_clr  in  1  clears both sticky error flags

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - pc_out=RESET_ADDR, depth=0, stack_empty=1, stack_full=0.
  - overflow_err=0, underflow_err=0, tos=0.
  - Stack RAM contents are not reset and are never visible while invalid.
- Reset has priority over every command. A CALL/RET coincident with reset is discarded.
- All state updates on the rising clk edge. Latency is 1 cycle: command in cycle N, new pc_out/depth/tos visible in cycle N+1.
- pc_en=0: PC, stack and depth hold. err_clr still acts.
- pc_op encodings, when pc_en=1:
  - 0 INC: pc <= pc+1.
  - 1 LOAD: pc <= pc_in.
  - 2 BRANCH: pc <= pc + sign_extend(offset).
  - 3 CALL: push (pc+1), then pc <= pc_in.
  - 4 RET: pc <= tos, pop.
  - 5 HOLD: no change.
  - 6, 7 reserved: behave as HOLD and raise no error.
- Arithmetic is modulo 2^ADDR_WIDTH with no saturation:
  - INC at all-ones gives 0.
  - CALL from all-ones pushes 0.
  - BRANCH wraps in both directions.
- CALL while stack_full:
  - overflow_err <= 1.
  - PC, stack and depth unchanged. The call is not taken.
- RET while stack_empty:
  - underflow_err <= 1.
  - PC and depth unchanged.
- Stack is a LIFO with write pointer = depth. Push writes entry[depth] and increments depth; pop decrements depth.
- tos = entry[depth-1] when depth>0, else 0. tos is combinational from registered state.
- Error flag update in the same cycle: err_clr and a new error event → the flag ends up 1 (set wins). err_clr alone → 0.
- A full CALL/RET sequence to depth STACK_DEPTH and back returns exactly the pushed addresses in reverse order.

Decomposition:
- Shared package holds:
  - PC_OP_INC/LOAD/BRANCH/CALL/RET/HOLD localparams.
  - PC_OP_WIDTH=3.
- One natural sub-module: call_stack.
  - Parametrised LIFO: push, pop, din, tos, depth, full, empty.
  - Push-when-full and pop-when-empty are ignored internally.
- pc_stack_unit owns the PC register, next-PC mux, error logic and command decode.

Test Plan:
1. Reset, then pc_en=1 INC ×3 with RESET_ADDR=0x0100 → pc_out 0x0101, 0x0102, 0x0103 on successive cycles; depth=0, stack_empty=1.
2. pc=0x0010, BRANCH offset=0xFE (−2) → pc_out 0x000E. pc=0xFFFF, INC → 0x0000. pc=0xFFF0, BRANCH offset=0x7F → 0x006F.
3. pc=0x0020, CALL pc_in=0x0400 → pc_out 0x0400, tos 0x0021, depth 1. Then RET → pc_out 0x0021, depth 0, tos 0.
4. Eight nested CALLs (STACK_DEPTH=8) → stack_full=1. Ninth CALL pc_in=0x0777 → overflow_err=1, pc_out and depth=8 unchanged. Eight RETs → addresses come back in reverse order.
5. RET with empty stack → underflow_err=1, pc unchanged. Next cycle err_clr=1 with another empty RET → underflow_err stays 1. err_clr alone → 0.
6. Mid-sequence (depth=3, pc=0x0123) assert reset with CALL → pc_out=RESET_ADDR, depth 0, errors 0. Held pc_en=0 with pc_op=CALL → no change.
